// File: rtl/int_ctrl_pkg.sv
// Interrupt codes shared with CP0 and the controller FSM state encoding.
// Pure declarations, no timing or handshake.
package int_ctrl_pkg;

    localparam logic [1:0] INT_NONE     = 2'b00;
    localparam logic [1:0] INT_EXTDEV   = 2'b01;
    localparam logic [1:0] INT_ILLINST  = 2'b10;
    localparam logic [1:0] INT_OVERFLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ISSUE      = 2'b01,
        ST_IN_SERVICE = 2'b10
    } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder, bit 0 wins; one-hot grant plus any-request flag.
// Purely combinational, zero latency, no backpressure.
module int_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [N-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt/exception request source for CP0: one registered code per entry, 2-cycle min latency,
// Stall holds requests pending in IDLE; level-sensitive external lines when INT_CTRL_LEVEL_EN is defined.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_EXT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EXT-1:0] ExtIrq,
    input  logic               IllegalInst,
    input  logic               Overflow,
    input  logic               IntEnable,
    input  logic               Stall,
    input  logic               Eret,
    output logic [1:0]         Interrupt,
    output logic [NUM_EXT-1:0] IrqAck,
    output logic               InService
);

    state_e             state_q, state_d;
    logic               pend_ov_q, pend_ov_d;
    logic               pend_ill_q, pend_ill_d;
    logic [NUM_EXT-1:0] pend_ext_q, pend_ext_d;
    logic [1:0]         interrupt_q, interrupt_d;
    logic [NUM_EXT-1:0] irq_ack_q, irq_ack_d;
    logic               in_service_q, in_service_d;

    logic [NUM_EXT-1:0] ext_cand;
    logic [NUM_EXT-1:0] ext_gnt;
    logic               ext_vld;
    logic [1:0]         win_code;
    logic               issue;

    assign ext_cand = pend_ext_q & {NUM_EXT{IntEnable}};

    int_prio_enc #(.N(NUM_EXT)) u_prio (
        .req (ext_cand),
        .vld (ext_vld),
        .gnt (ext_gnt)
    );

    always_comb begin
        if (pend_ov_q)       win_code = INT_OVERFLOW;
        else if (pend_ill_q) win_code = INT_ILLINST;
        else if (ext_vld)    win_code = INT_EXTDEV;
        else                 win_code = INT_NONE;
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        interrupt_d = INT_NONE;
        irq_ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_code != INT_NONE && !Stall) begin
                    state_d     = ST_ISSUE;
                    issue       = 1'b1;
                    interrupt_d = win_code;
                    if (win_code == INT_EXTDEV) irq_ack_d = ext_gnt;
                end
            end
            ST_ISSUE:      state_d = ST_IN_SERVICE;
            ST_IN_SERVICE: if (Eret) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        in_service_d = (state_d != ST_IDLE);
    end

    // Set terms are OR'd after the clear so a same-cycle event survives its own issue.
    always_comb begin
        pend_ov_d  = (pend_ov_q  & ~(issue && win_code == INT_OVERFLOW)) | Overflow;
        pend_ill_d = (pend_ill_q & ~(issue && win_code == INT_ILLINST))  | IllegalInst;
    end

`ifdef INT_CTRL_LEVEL_EN
    always_comb begin
        pend_ext_d = ExtIrq;
    end
`else
    logic [NUM_EXT-1:0] ext_prev_q, ext_prev_d;
    logic [NUM_EXT-1:0] ext_clr;

    always_comb begin
        ext_clr    = (issue && win_code == INT_EXTDEV) ? ext_gnt : '0;
        pend_ext_d = (pend_ext_q & ~ext_clr) | (ExtIrq & ~ext_prev_q);
        ext_prev_d = ExtIrq;
    end

    always_ff @(posedge clk) begin
        if (rst) ext_prev_q <= '0;
        else     ext_prev_q <= ext_prev_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_ov_q    <= 1'b0;
            pend_ill_q   <= 1'b0;
            pend_ext_q   <= '0;
            interrupt_q  <= INT_NONE;
            irq_ack_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_ov_q    <= pend_ov_d;
            pend_ill_q   <= pend_ill_d;
            pend_ext_q   <= pend_ext_d;
            interrupt_q  <= interrupt_d;
            irq_ack_q    <= irq_ack_d;
            in_service_q <= in_service_d;
        end
    end

    assign Interrupt = interrupt_q;
    assign IrqAck    = irq_ack_q;
    assign InService = in_service_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus random traffic, every cycle checked against a pending-set/handler-busy model.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int NUM_EXT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NUM_EXT-1:0] ext_irq = '0;
    logic               illegal_inst = 1'b0;
    logic               overflow = 1'b0;
    logic               int_enable = 1'b0;
    logic               stall = 1'b0;
    logic               eret = 1'b0;
    logic [1:0]         interrupt;
    logic [NUM_EXT-1:0] irq_ack;
    logic               in_service;

    int tests = 0;
    int fails = 0;

    int_ctrl #(.NUM_EXT(NUM_EXT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ExtIrq      (ext_irq),
        .IllegalInst (illegal_inst),
        .Overflow    (overflow),
        .IntEnable   (int_enable),
        .Stall       (stall),
        .Eret        (eret),
        .Interrupt   (interrupt),
        .IrqAck      (irq_ack),
        .InService   (in_service)
    );

    always #5 clk = ~clk;

    // Reference: sets of pending requests, whether a handler is active, and what is being presented.
    bit                 m_ov, m_ill, m_busy;
    bit [NUM_EXT-1:0]   m_ext, m_prev;
    logic [1:0]         m_code;
    logic [NUM_EXT-1:0] m_ack;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [1:0]         code;
        logic [NUM_EXT-1:0] ack;
        bit                 go;
        code = INT_NONE;
        ack  = '0;
        go   = 1'b0;
        if (rst) begin
            m_ov = 0; m_ill = 0; m_ext = '0; m_prev = '0; m_busy = 0;
            m_code = INT_NONE; m_ack = '0;
            return;
        end
        if (!m_busy) begin
            if (m_ov)       code = INT_OVERFLOW;
            else if (m_ill) code = INT_ILLINST;
            else if (int_enable && m_ext != '0) begin
                code = INT_EXTDEV;
                for (int i = NUM_EXT - 1; i >= 0; i--)
                    if (m_ext[i]) begin ack = '0; ack[i] = 1'b1; end
            end
            go = (code != INT_NONE) && !stall;
            if (!go) begin code = INT_NONE; ack = '0; end
        end
        if (go) begin
            if (code == INT_OVERFLOW)     m_ov = 0;
            else if (code == INT_ILLINST) m_ill = 0;
`ifndef INT_CTRL_LEVEL_EN
            else m_ext = m_ext & ~ack;
`endif
        end
        // A return is honoured only once the issue cycle is over.
        if (m_busy && m_code == INT_NONE && eret) m_busy = 0;
        else if (go)                               m_busy = 1;
        m_ov  = m_ov  | overflow;
        m_ill = m_ill | illegal_inst;
`ifdef INT_CTRL_LEVEL_EN
        m_ext = ext_irq;
`else
        m_ext  = m_ext | (ext_irq & ~m_prev);
        m_prev = ext_irq;
`endif
        m_code = code;
        m_ack  = ack;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_interrupt", 8'(interrupt), 8'(m_code));
        chk("model_irqack", 8'(irq_ack), 8'(m_ack));
        chk("model_inservice", 8'(in_service), 8'(m_busy));
    endtask

    task automatic ret();
        eret = 1'b1;
        cycle();
        eret = 1'b0;
    endtask

    initial begin
        // Reset and overflow pulse at cycle 3
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        chk("reset_interrupt", 8'(interrupt), 8'h00);
        chk("reset_irqack", 8'(irq_ack), 8'h00);
        chk("reset_inservice", 8'(in_service), 8'h00);
        cycle(); cycle();
        overflow = 1'b1;
        cycle();
        overflow = 1'b0;
        chk("ov_not_yet", 8'(interrupt), 8'h00);
        cycle();
        chk("ov_issue", 8'(interrupt), 8'h03);
        chk("ov_inservice", 8'(in_service), 8'h01);
        cycle();
        chk("ov_one_cycle", 8'(interrupt), 8'h00);
        chk("ov_still_inservice", 8'(in_service), 8'h01);
        cycle(); cycle();
        ret();
        chk("ov_returned", 8'(in_service), 8'h00);

        // Illegal instruction beats a simultaneous external edge
        int_enable = 1'b1;
        illegal_inst = 1'b1;
        ext_irq = 4'b0100;
        cycle();
        illegal_inst = 1'b0;
        cycle();
        chk("ill_first", 8'(interrupt), 8'h02);
        cycle();
        ret();
        cycle();
        chk("ext_after_ill", 8'(interrupt), 8'h01);
        chk("ext_after_ill_ack", 8'(irq_ack), 8'b0100);
        ext_irq = '0;
        cycle();
        ret();
        cycle(); cycle();

`ifndef INT_CTRL_LEVEL_EN
        // Edges captured while disabled, issued lowest index first once enabled
        int_enable = 1'b0;
        ext_irq = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("disabled_no_issue", 8'(interrupt), 8'h00);
        end
        int_enable = 1'b1;
        cycle();
        chk("enable_ack1", 8'(irq_ack), 8'b0010);
        cycle();
        ret();
        cycle();
        chk("enable_ack2", 8'(irq_ack), 8'b0100);
        cycle();
        ret();
        ext_irq = '0;
        cycle(); cycle();
`endif

        // Stall holds a pending overflow
        stall = 1'b1;
        overflow = 1'b1;
        cycle();
        overflow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_hold", 8'(interrupt), 8'h00);
        end
        stall = 1'b0;
        cycle();
        chk("stall_release", 8'(interrupt), 8'h03);
        cycle();
        ret();

        // Reset during service discards pending ext[0]
        overflow = 1'b1;
        cycle();
        overflow = 1'b0;
        cycle(); cycle();
        ext_irq = 4'b0001;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        ext_irq = '0;
        cycle();
        rst = 1'b0;
        chk("rst_interrupt", 8'(interrupt), 8'h00);
        chk("rst_irqack", 8'(irq_ack), 8'h00);
        chk("rst_inservice", 8'(in_service), 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_no_issue", 8'(interrupt), 8'h00);
        end

`ifdef INT_CTRL_LEVEL_EN
        // Held level re-issues after each return
        ext_irq = 4'b0010;
        cycle(); cycle();
        chk("level_first", 8'(interrupt), 8'h01);
        chk("level_first_ack", 8'(irq_ack), 8'b0010);
        cycle();
        ret();
        cycle();
        chk("level_again", 8'(interrupt), 8'h01);
        chk("level_again_ack", 8'(irq_ack), 8'b0010);
        ext_irq = '0;
        cycle();
        ret();
        cycle(); cycle();
`endif

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            overflow     = ($urandom_range(0, 15) == 0);
            illegal_inst = ($urandom_range(0, 15) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            eret         = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) int_enable = ~int_enable;
            for (int b = 0; b < NUM_EXT; b++)
                if ($urandom_range(0, 7) == 0) ext_irq[b] = ~ext_irq[b];
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
